// File: rtl/mux_pkg.sv
// Shared types and constants for the N-way streaming multiplexer.
package mux_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, wrapping modulo WAYS.
module rr_arbiter #(
    parameter  int WAYS  = 4,
    localparam int SEL_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [WAYS-1:0]  gnt,
    output logic [SEL_W-1:0] idx
);

    // One extra bit so ptr + k cannot overflow before the modulo fold.
    localparam int IW = SEL_W + 1;

    logic [IW-1:0] w_cand;
    logic          w_found;

    // First requester at or after ptr wins; later candidates are ignored.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < WAYS; k++) begin
            w_cand = {1'b0, ptr} + IW'(k);
            if (w_cand >= IW'(WAYS)) begin
                w_cand = w_cand - IW'(WAYS);
            end else begin
                w_cand = w_cand;
            end
            if (!w_found && req[w_cand[SEL_W-1:0]]) begin
                gnt[w_cand[SEL_W-1:0]] = 1'b1;
                idx                    = w_cand[SEL_W-1:0];
                w_found                = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/mux_n_way_stream.sv
// WAYS-input streaming mux with fixed-select or round-robin grant and a registered output stage.
// Optional transfer counter enabled by defining MUX_XFER_CNT_EN.
module mux_n_way_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int WAYS  = 4,
    localparam int SEL_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_XFER_CNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [WAYS-1:0]  w_rr_gnt;
    logic [SEL_W-1:0] w_rr_idx;
    logic [WAYS-1:0]  w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic             w_load_ok;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    mux_mode_t        w_mode;

    assign w_mode = mux_mode_t'(mode);

    rr_arbiter #(.WAYS(WAYS)) u_rr_arbiter (
        .req (in_valid),
        .ptr (r_ptr),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx)
    );

    // Grant selection: round-robin result or the explicitly selected channel (none if out of range).
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        if (w_mode == MODE_RR) begin
            w_grant = w_rr_gnt;
            w_gidx  = w_rr_idx;
        end else if (int'(select) < WAYS) begin
            w_grant[select] = in_valid[select];
            w_gidx          = select;
        end else begin
            w_grant = '0;
            w_gidx  = '0;
        end
    end

    // Holding reset low also blocks acceptance, so no beat is taken while in reset.
    assign w_load_ok  = (!r_out_valid || out_ready) && rst_n;
    assign in_ready   = w_grant & {WAYS{w_load_ok}};
    assign w_accept   = |in_ready;
    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];

    // Output register and round-robin pointer; a new beat wins over a simultaneous drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_gidx;
            r_out_valid <= 1'b1;
            if (w_mode == MODE_RR) begin
                r_ptr <= (w_gidx == SEL_W'(WAYS - 1)) ? '0 : w_gidx + SEL_W'(1);
            end else begin
                r_ptr <= r_ptr;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

`ifdef MUX_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] r_xfer_cnt;

    // Counts output handshakes, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign xfer_count = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_n_way_stream.sv
// Directed self-checking bench for mux_n_way_stream (4-way/16-bit and 3-way/8-bit instances).
`timescale 1ns/1ps
module tb_mux_n_way_stream;

    logic        clk;
    logic        rst_n;

    logic [63:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [1:0]  select4;
    logic [15:0] out_data4;
    logic [1:0]  out_chan4;
    logic        out_valid4;
    logic        out_ready4;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  select3;
    logic [7:0]  out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3;
    logic        out_ready3;

`ifdef MUX_XFER_CNT_EN
    logic [15:0] xfer_count4;
    logic [15:0] xfer_count3;
`endif

    int errors;
    int checks;

    mux_n_way_stream #(.WIDTH(16), .WAYS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mode      (mode4),
        .select    (select4),
        .out_data  (out_data4),
        .out_chan  (out_chan4),
        .out_valid (out_valid4),
        .out_ready (out_ready4)
`ifdef MUX_XFER_CNT_EN
        ,
        .xfer_count(xfer_count4)
`endif
    );

    mux_n_way_stream #(.WIDTH(8), .WAYS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .select    (select3),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef MUX_XFER_CNT_EN
        ,
        .xfer_count(xfer_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rr_data();
        for (int i = 0; i < 4; i++) begin
            in_data4[i*16 +: 16] = 16'hA000 + 16'(i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 4'hF; mode4 = 1'b0; select4 = 2'd0; out_ready4 = 1'b1;
        in_data4 = 64'h0;
        in_valid3 = 3'b000; mode3 = 1'b0; select3 = 2'd0; out_ready3 = 1'b1;
        in_data3 = 24'h0;
        #2;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid4); end
        checks++; if (out_data4 !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", out_data4); end
        checks++; if (out_chan4 !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d exp 0", out_chan4); end
        checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b exp 0000", in_ready4); end
`ifdef MUX_XFER_CNT_EN
        checks++; if (xfer_count4 !== 16'd0) begin errors++; $display("FAIL reset_xfer got %0d exp 0", xfer_count4); end
`endif
        in_valid4 = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        mode4 = 1'b0; select4 = 2'd2; out_ready4 = 1'b1;
        in_data4 = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
        in_valid4 = 4'b0100;
        #1;
        checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready got %b exp 0100", in_ready4); end
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL fixed_pre_valid got %b exp 0", out_valid4); end
        tick();
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL fixed_valid got %b exp 1", out_valid4); end
        checks++; if (out_data4 !== 16'hBEEF) begin errors++; $display("FAIL fixed_data got %h exp beef", out_data4); end
        checks++; if (out_chan4 !== 2'd2) begin errors++; $display("FAIL fixed_chan got %0d exp 2", out_chan4); end
    endtask

    task automatic test_backpressure();
        out_ready4 = 1'b0;
        in_data4[2*16 +: 16] = 16'h1234;
        #1;
        checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL bp_in_ready got %b exp 0000", in_ready4); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_data4 !== 16'hBEEF) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h exp beef", c, out_data4); end
            checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", c, out_valid4); end
            checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready cyc %0d got %b exp 0000", c, in_ready4); end
        end
        out_ready4 = 1'b1;
        #1;
        checks++; if (in_ready4 !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b exp 0100", in_ready4); end
        tick();
        checks++; if (out_data4 !== 16'h1234) begin errors++; $display("FAIL bp_new_data got %h exp 1234", out_data4); end
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL bp_new_valid got %b exp 1", out_valid4); end
        in_valid4 = 4'b0000;
        tick();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid4); end
        checks++; if (out_data4 !== 16'h1234) begin errors++; $display("FAIL drain_keep_data got %h exp 1234", out_data4); end
        checks++; if (out_chan4 !== 2'd2) begin errors++; $display("FAIL drain_keep_chan got %0d exp 2", out_chan4); end
`ifdef MUX_XFER_CNT_EN
        checks++; if (xfer_count4 !== 16'd2) begin errors++; $display("FAIL xfer_after_fixed got %0d exp 2", xfer_count4); end
`endif
    endtask

    task automatic test_rr_all();
        logic [1:0] exp_seq [6];
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mode4 = 1'b1; out_ready4 = 1'b1;
        load_rr_data();
        in_valid4 = 4'b1111;
        #1;
        checks++; if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", in_ready4); end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (out_chan4 !== exp_seq[k]) begin errors++; $display("FAIL rr_chan step %0d got %0d exp %0d", k, out_chan4, exp_seq[k]); end
            checks++; if (out_data4 !== (16'hA000 + 16'(exp_seq[k]))) begin errors++; $display("FAIL rr_data step %0d got %h exp %h", k, out_data4, 16'hA000 + 16'(exp_seq[k])); end
        end
        in_valid4 = 4'b0000;
        tick();
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", out_valid4); end
`ifdef MUX_XFER_CNT_EN
        checks++; if (xfer_count4 !== 16'd8) begin errors++; $display("FAIL xfer_after_rr got %0d exp 8", xfer_count4); end
`endif
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
        in_valid4 = 4'b1010;
        #1;
        checks++; if (in_ready4 !== 4'b1000) begin errors++; $display("FAIL sparse_ready got %b exp 1000", in_ready4); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_chan4 !== exp_seq[k]) begin errors++; $display("FAIL sparse_chan step %0d got %0d exp %0d", k, out_chan4, exp_seq[k]); end
        end
        in_valid4 = 4'b0010;
        #1;
        checks++; if (in_ready4 !== 4'b0010) begin errors++; $display("FAIL only_ch1_ready got %b exp 0010", in_ready4); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (out_chan4 !== 2'd1) begin errors++; $display("FAIL only_ch1_chan step %0d got %0d exp 1", k, out_chan4); end
            checks++; if (out_data4 !== 16'hA001) begin errors++; $display("FAIL only_ch1_data step %0d got %h exp a001", k, out_data4); end
        end
        in_valid4 = 4'b0000;
        tick();
`ifdef MUX_XFER_CNT_EN
        checks++; if (xfer_count4 !== 16'd14) begin errors++; $display("FAIL xfer_after_sparse got %0d exp 14", xfer_count4); end
`endif
    endtask

    task automatic test_ways3_out_of_range();
        in_data3 = {8'h52, 8'h51, 8'h50};
        mode3 = 1'b0; select3 = 2'd3; out_ready3 = 1'b1;
        in_valid3 = 3'b111;
        #1;
        checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL w3_oor_ready got %b exp 000", in_ready3); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL w3_oor_valid cyc %0d got %b exp 0", c, out_valid3); end
        end
        select3 = 2'd2;
        #1;
        checks++; if (in_ready3 !== 3'b100) begin errors++; $display("FAIL w3_sel2_ready got %b exp 100", in_ready3); end
        tick();
        checks++; if (out_data3 !== 8'h52) begin errors++; $display("FAIL w3_sel2_data got %h exp 52", out_data3); end
        checks++; if (out_chan3 !== 2'd2) begin errors++; $display("FAIL w3_sel2_chan got %0d exp 2", out_chan3); end
        in_valid3 = 3'b000;
        tick();
    endtask

    task automatic test_reset_midstream();
        mode4 = 1'b1; out_ready4 = 1'b1;
        load_rr_data();
        in_valid4 = 4'b1111;
        tick();
        checks++; if (out_chan4 !== 2'd2) begin errors++; $display("FAIL mid_pre_chan0 got %0d exp 2", out_chan4); end
        tick();
        checks++; if (out_chan4 !== 2'd3) begin errors++; $display("FAIL mid_pre_chan1 got %0d exp 3", out_chan4); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid4); end
        checks++; if (out_data4 !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got %h exp 0000", out_data4); end
        checks++; if (out_chan4 !== 2'd0) begin errors++; $display("FAIL mid_rst_chan got %0d exp 0", out_chan4); end
        checks++; if (in_ready4 !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", in_ready4); end
`ifdef MUX_XFER_CNT_EN
        checks++; if (xfer_count4 !== 16'd0) begin errors++; $display("FAIL mid_rst_xfer got %0d exp 0", xfer_count4); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready4 !== 4'b0001) begin errors++; $display("FAIL post_rst_ready got %b exp 0001", in_ready4); end
        tick();
        checks++; if (out_chan4 !== 2'd0) begin errors++; $display("FAIL post_rst_chan got %0d exp 0", out_chan4); end
        checks++; if (out_data4 !== 16'hA000) begin errors++; $display("FAIL post_rst_data got %h exp a000", out_data4); end
        checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b exp 1", out_valid4); end
        in_valid4 = 4'b0000;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        tick();
        test_fixed();
        test_backpressure();
        test_rr_all();
        test_rr_sparse();
        test_ways3_out_of_range();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
